// File: rtl/prfc_if.sv
// Packet stream bundle for the pipelined RFC classifier: header dims in,
// rule result out, each side with a valid/ready handshake.
interface prfc_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           packet_dims_0;
  logic [15:0]           packet_dims_1;
  logic [15:0]           packet_dims_2;
  logic [15:0]           packet_dims_3;
  logic [15:0]           packet_dims_4;
  logic [15:0]           packet_dims_5;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] lookup_result;

  modport master (
    output in_valid, packet_dims_0, packet_dims_1, packet_dims_2,
           packet_dims_3, packet_dims_4, packet_dims_5, out_ready,
    input  in_ready, out_valid, lookup_result
  );

  modport slave (
    input  in_valid, packet_dims_0, packet_dims_1, packet_dims_2,
           packet_dims_3, packet_dims_4, packet_dims_5, out_ready,
    output in_ready, out_valid, lookup_result
  );
endinterface

// File: rtl/prfc_pipelined_classifier.sv
// Fully pipelined 3-phase RFC classifier with config-loaded RAM tables.
// Optional statistics counters are built when PRFC_STATS_EN is defined.
module prfc_pipelined_classifier #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    P0_IDX_W     = 8,
  parameter int                    EQ_W0        = 4,
  parameter int                    EQ_W1        = 6,
  parameter logic [DATA_WIDTH-1:0] NOMATCH_CODE = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prfc_if.slave                 pkt,
  output logic                  busy,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_sel,
  input  logic [15:0]           cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  input  logic                  stat_clr,
  output logic [31:0]           stat_lookups,
  output logic [31:0]           stat_nomatch
);
  localparam int P0_DEPTH  = 1 << P0_IDX_W;
  localparam int P1_IDX_W  = 3 * EQ_W0;
  localparam int P1_DEPTH  = 1 << P1_IDX_W;
  localparam int FIN_IDX_W = 2 * EQ_W1;
  localparam int FIN_DEPTH = 1 << FIN_IDX_W;

  logic stall;
  logic advance;
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] lookup_result_q;

  // A result held at the output freezes every stage behind it.
  assign stall        = out_valid_q & ~pkt.out_ready;
  assign advance      = ~stall;
  assign pkt.in_ready = advance;
  assign pkt.out_valid     = out_valid_q;
  assign pkt.lookup_result = lookup_result_q;
  assign busy = v1_q | v2_q | out_valid_q;

  logic [5:0][15:0] dims;
  assign dims = {pkt.packet_dims_5, pkt.packet_dims_4, pkt.packet_dims_3,
                 pkt.packet_dims_2, pkt.packet_dims_1, pkt.packet_dims_0};

  // Phase 0: one chunk table per header field.
  logic [5:0][EQ_W0-1:0] eq0;

  for (genvar i = 0; i < 6; i++) begin : g_p0
    logic [DATA_WIDTH-1:0] mem [P0_DEPTH];
    logic [DATA_WIDTH-1:0] data_q;
    logic                  unused_p0;

    // NOTE: table RAMs are deliberately left out of reset; a reset branch
    // would turn them into flop arrays and software reloads them anyway.
    always_ff @(posedge clk) begin
      if (cfg_we && cfg_sel == 4'(i)) mem[cfg_addr[P0_IDX_W-1:0]] <= cfg_wdata;
      if (advance && pkt.in_valid) data_q <= mem[dims[i][15 -: P0_IDX_W]];
    end

    assign eq0[i]    = data_q[EQ_W0-1:0];
    assign unused_p0 = ^data_q;
  end

  // Phase 1: combine eqIDs {0,1,2} and {3,4,5}, lower dim in the MSBs.
  logic [DATA_WIDTH-1:0] p1a_mem [P1_DEPTH];
  logic [DATA_WIDTH-1:0] p1b_mem [P1_DEPTH];
  logic [DATA_WIDTH-1:0] p1a_q, p1b_q;
  logic [P1_IDX_W-1:0]   p1a_addr, p1b_addr;

  assign p1a_addr = {eq0[0], eq0[1], eq0[2]};
  assign p1b_addr = {eq0[3], eq0[4], eq0[5]};

  // NOTE: non-blocking assignments on both the write and the read give the
  // old entry to a read that collides with a write in the same cycle.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_sel == 4'd6) p1a_mem[cfg_addr[P1_IDX_W-1:0]] <= cfg_wdata;
    if (cfg_we && cfg_sel == 4'd7) p1b_mem[cfg_addr[P1_IDX_W-1:0]] <= cfg_wdata;
    if (advance && v1_q) begin
      p1a_q <= p1a_mem[p1a_addr];
      p1b_q <= p1b_mem[p1b_addr];
    end
  end

  // Final phase: the RAM output register doubles as the result register.
  logic [DATA_WIDTH-1:0] fin_mem [FIN_DEPTH];
  logic [FIN_IDX_W-1:0]  fin_addr;

  assign fin_addr = {p1a_q[EQ_W1-1:0], p1b_q[EQ_W1-1:0]};

  always_ff @(posedge clk) begin
    if (cfg_we && cfg_sel == 4'd8) fin_mem[cfg_addr[FIN_IDX_W-1:0]] <= cfg_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              lookup_result_q <= '0;
    else if (advance && v2_q) lookup_result_q <= fin_mem[fin_addr];
  end

  // NOTE: every always_comb output takes its hold value first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    v1_d        = v1_q;
    v2_d        = v2_q;
    out_valid_d = out_valid_q;
    if (advance) begin
      v1_d        = pkt.in_valid;
      v2_d        = v1_q;
      out_valid_d = v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
    end
  end

  logic is_nomatch;
  assign is_nomatch = (lookup_result_q == NOMATCH_CODE);

`ifdef PRFC_STATS_EN
  logic        fire;
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_nomatch_q, stat_nomatch_d;

  assign fire = out_valid_q & pkt.out_ready;

  // Clear wins over a same-cycle completion; both counters saturate.
  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_nomatch_d = stat_nomatch_q;
    if (stat_clr) begin
      stat_lookups_d = '0;
      stat_nomatch_d = '0;
    end else if (fire) begin
      if (stat_lookups_q != '1)              stat_lookups_d = stat_lookups_q + 32'd1;
      if (is_nomatch && stat_nomatch_q != '1) stat_nomatch_d = stat_nomatch_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_lookups_q <= '0;
      stat_nomatch_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_nomatch_q <= stat_nomatch_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_nomatch = stat_nomatch_q;
`else
  logic unused_stat;
  assign unused_stat  = stat_clr ^ is_nomatch;
  assign stat_lookups = '0;
  assign stat_nomatch = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{cfg_addr, p1a_q, p1b_q};
endmodule
